// File: rtl/ps2_mode_controller.sv
// PS/2 keyboard front end for the step sequencer: scan-code decoder (E0/F0,
// typematic suppression) feeding an IDLE / EDIT[i] / PLAY mode selector.
module ps2_mode_controller #(
  parameter int                     NUM_MODES = 3,
  parameter logic [8*NUM_MODES-1:0] MODE_KEYS = 24'h3A_324B,
  parameter logic [7:0]             KEY_ENTER = 8'h5A,
  parameter logic [7:0]             KEY_ESC   = 8'h76,
  parameter logic [7:0]             KEY_PLAY  = 8'h29,
  parameter bit                     REPEAT_EN = 1'b0,
  parameter int                     BLINK_DIV = 1250000
) (
  input  logic                 CLOCK_50,
  input  logic                 nReset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_en,
  input  logic                 bpm_ok,
  input  logic                 play_en,
  output logic [NUM_MODES-1:0] mode_sel,
  output logic                 playing,
  output logic                 start,
  output logic                 stop_req,
  output logic                 abort,
  output logic                 fwd_valid,
  output logic [7:0]           fwd_code,
  output logic                 fwd_ext,
  output logic [NUM_MODES-1:0] led_mode,
  output logic                 led_play
);

  localparam int             IW         = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int             CW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0]  BLINK_LAST = CW'(BLINK_DIV - 1);
  localparam logic [7:0]     CODE_EXT   = 8'hE0;
  localparam logic [7:0]     CODE_BRK   = 8'hF0;

  typedef enum logic [1:0] {D_NONE, D_EXT, D_BRK, D_EXT_BRK} dec_t;
  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_PLAY} mode_t;

  // ---------------- scan-code decoder ----------------
  dec_t       r_dstate, w_dstate_nxt;
  logic       r_held_vld, w_held_vld_nxt;
  logic [7:0] r_held_code, w_held_code_nxt;
  logic       r_held_ext, w_held_ext_nxt;
  logic       w_ev_vld;
  logic       w_in_brk, w_in_ext, w_held_hit;
  logic       r_key_vld;
  logic [7:0] r_key_code;
  logic       r_key_ext;

  assign w_in_brk   = (r_dstate == D_BRK) || (r_dstate == D_EXT_BRK);
  assign w_in_ext   = (r_dstate == D_EXT) || (r_dstate == D_EXT_BRK);
  assign w_held_hit = r_held_vld && (rx_data == r_held_code) && (w_in_ext == r_held_ext);

  always_comb begin
    w_dstate_nxt    = r_dstate;
    w_held_vld_nxt  = r_held_vld;
    w_held_code_nxt = r_held_code;
    w_held_ext_nxt  = r_held_ext;
    w_ev_vld        = 1'b0;
    if (rx_en) begin
      if (rx_data == CODE_EXT) begin
        w_dstate_nxt = w_in_brk ? D_EXT_BRK : D_EXT;
      end else if (rx_data == CODE_BRK) begin
        w_dstate_nxt = w_in_ext ? D_EXT_BRK : D_BRK;
      end else begin
        w_dstate_nxt = D_NONE;
        if (w_in_brk) begin
          if (w_held_hit) w_held_vld_nxt = 1'b0;
        end else if (!w_held_hit || REPEAT_EN) begin
          // the held key is the one a typematic repeat would re-send
          w_ev_vld        = 1'b1;
          w_held_vld_nxt  = 1'b1;
          w_held_code_nxt = rx_data;
          w_held_ext_nxt  = w_in_ext;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      r_dstate    <= D_NONE;
      r_held_vld  <= 1'b0;
      r_held_code <= 8'h00;
      r_held_ext  <= 1'b0;
      r_key_vld   <= 1'b0;
      r_key_code  <= 8'h00;
      r_key_ext   <= 1'b0;
    end else begin
      r_dstate    <= w_dstate_nxt;
      r_held_vld  <= w_held_vld_nxt;
      r_held_code <= w_held_code_nxt;
      r_held_ext  <= w_held_ext_nxt;
      r_key_vld   <= w_ev_vld;
      if (w_ev_vld) begin
        r_key_code <= rx_data;
        r_key_ext  <= w_in_ext;
      end
    end
  end

  // ---------------- mode FSM ----------------
  mode_t          r_state, w_state_nxt;
  logic [IW-1:0]  r_mode_idx, w_mode_idx_nxt;
  logic           r_play_first;
  logic           w_key_plain, w_mode_hit;
  logic [IW-1:0]  w_mode_hit_idx;
  logic           w_start_nxt, w_stop_nxt, w_abort_nxt, w_fwd_nxt;
  logic           r_start, r_stop, r_abort, r_fwd_vld, r_fwd_ext;
  logic [7:0]     r_fwd_code;
  logic [NUM_MODES-1:0] w_mode_sel;

  assign w_key_plain = r_key_vld && !r_key_ext;

  always_comb begin
    w_mode_hit     = 1'b0;
    w_mode_hit_idx = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (MODE_KEYS[8*i +: 8] == r_key_code) begin
        w_mode_hit     = 1'b1;
        w_mode_hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_mode_idx_nxt = r_mode_idx;
    w_start_nxt    = 1'b0;
    w_stop_nxt     = 1'b0;
    w_abort_nxt    = 1'b0;
    w_fwd_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_key_plain) begin
          if (w_mode_hit) begin
            w_state_nxt    = S_EDIT;
            w_mode_idx_nxt = w_mode_hit_idx;
          end else if (r_key_code == KEY_PLAY && bpm_ok) begin
            w_state_nxt = S_PLAY;
            w_start_nxt = 1'b1;
          end
        end
      end
      S_EDIT: begin
        if (w_key_plain && r_key_code == KEY_ENTER) begin
          w_state_nxt = S_IDLE;
        end else if (w_key_plain && r_key_code == KEY_ESC) begin
          w_state_nxt = S_IDLE;
          w_abort_nxt = 1'b1;
        end else if (r_key_vld) begin
          w_fwd_nxt = 1'b1;
        end
      end
      S_PLAY: begin
        // ESC wins over a simultaneous play_en drop so the player still sees stop_req
        if (w_key_plain && r_key_code == KEY_ESC) begin
          w_state_nxt = S_IDLE;
          w_stop_nxt  = 1'b1;
        end else if (!play_en && !r_play_first) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mode_sel = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      w_mode_sel[i] = (r_state == S_EDIT) && (r_mode_idx == IW'(i));
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      r_state      <= S_IDLE;
      r_mode_idx   <= '0;
      r_play_first <= 1'b0;
      r_start      <= 1'b0;
      r_stop       <= 1'b0;
      r_abort      <= 1'b0;
      r_fwd_vld    <= 1'b0;
      r_fwd_code   <= 8'h00;
      r_fwd_ext    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mode_idx   <= w_mode_idx_nxt;
      r_play_first <= (w_state_nxt == S_PLAY) && (r_state != S_PLAY);
      r_start      <= w_start_nxt;
      r_stop       <= w_stop_nxt;
      r_abort      <= w_abort_nxt;
      r_fwd_vld    <= w_fwd_nxt;
      if (w_fwd_nxt) begin
        r_fwd_code <= r_key_code;
        r_fwd_ext  <= r_key_ext;
      end
    end
  end

  // ---------------- blink and LEDs ----------------
  logic [CW-1:0]        r_blink_cnt;
  logic                 r_phase;
  logic [NUM_MODES-1:0] r_led_mode;
  logic                 r_led_play;

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_led_mode  <= '0;
      r_led_play  <= 1'b0;
    end else begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
      r_led_mode <= ~w_mode_sel | {NUM_MODES{r_phase}};
      r_led_play <= (r_state == S_PLAY);
    end
  end

  assign mode_sel  = w_mode_sel;
  assign playing   = (r_state == S_PLAY);
  assign start     = r_start;
  assign stop_req  = r_stop;
  assign abort     = r_abort;
  assign fwd_valid = r_fwd_vld;
  assign fwd_code  = r_fwd_code;
  assign fwd_ext   = r_fwd_ext;
  assign led_mode  = r_led_mode;
  assign led_play  = r_led_play;

endmodule
